// File: rtl/axil_master.sv
// AXI4-Lite initiator: one single-beat command in, one AXI4-Lite
// transaction out, one response back. At most one transaction in flight.
module axil_master #(
    parameter int         DATA_WIDTH = 32,
    parameter int         ADDR_WIDTH = 32,
    parameter int         STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [2:0] PROT       = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;
    localparam logic [2:0] S_RSP     = 3'd5;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  aw_done;
    logic                  w_done;
    logic                  aw_hs;
    logic                  w_hs;

    assign aw_hs = m_axil_awvalid & m_axil_awready;
    assign w_hs  = m_axil_wvalid & m_axil_wready;

    // Every output below is a register or a decode of the state register.
    assign cmd_ready     = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign m_axil_awaddr = addr_q;
    assign m_axil_araddr = addr_q;
    assign m_axil_wdata  = wdata_q;
    assign m_axil_wstrb  = wstrb_q;
    assign m_axil_awprot = PROT;
    assign m_axil_arprot = PROT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_write      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= 2'b00;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        wstrb_q <= cmd_wstrb;
                        if (cmd_write) begin
                            m_axil_awvalid <= 1'b1;
                            m_axil_wvalid  <= 1'b1;
                            aw_done        <= 1'b0;
                            w_done         <= 1'b0;
                            state          <= S_WR_REQ;
                        end else begin
                            m_axil_arvalid <= 1'b1;
                            state          <= S_RD_REQ;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (aw_hs) begin
                        m_axil_awvalid <= 1'b0;
                        aw_done        <= 1'b1;
                    end
                    if (w_hs) begin
                        m_axil_wvalid <= 1'b0;
                        w_done        <= 1'b1;
                    end
                    // Same-cycle or either-order completion of AW and W.
                    if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                        m_axil_bready <= 1'b1;
                        state         <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (m_axil_bvalid & m_axil_bready) begin
                        m_axil_bready <= 1'b0;
                        rsp_resp      <= m_axil_bresp;
                        rsp_write     <= 1'b1;
                        rsp_rdata     <= '0;
                        rsp_valid     <= 1'b1;
                        state         <= S_RSP;
                    end
                end
                S_RD_REQ: begin
                    if (m_axil_arvalid & m_axil_arready) begin
                        m_axil_arvalid <= 1'b0;
                        m_axil_rready  <= 1'b1;
                        state          <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (m_axil_rvalid & m_axil_rready) begin
                        m_axil_rready <= 1'b0;
                        rsp_rdata     <= m_axil_rdata;
                        rsp_resp      <= m_axil_rresp;
                        rsp_write     <= 1'b0;
                        rsp_valid     <= 1'b1;
                        state         <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_master.sv
// Directed cycle-accurate bench for axil_master with a hand-driven
// AXI4-Lite slave.
module tb_axil_master;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          busy;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    int tests = 0;
    int fails = 0;
    int aw_cnt = 0;
    int w_cnt = 0;
    int aw0;
    int w0;

    axil_master #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .STRB_WIDTH(SW),
        .PROT      (3'b000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_write     (rsp_write),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .busy          (busy),
        .m_axil_awaddr (awaddr),
        .m_axil_awprot (awprot),
        .m_axil_awvalid(awvalid),
        .m_axil_awready(awready),
        .m_axil_wdata  (wdata),
        .m_axil_wstrb  (wstrb),
        .m_axil_wvalid (wvalid),
        .m_axil_wready (wready),
        .m_axil_bresp  (bresp),
        .m_axil_bvalid (bvalid),
        .m_axil_bready (bready),
        .m_axil_araddr (araddr),
        .m_axil_arprot (arprot),
        .m_axil_arvalid(arvalid),
        .m_axil_arready(arready),
        .m_axil_rdata  (rdata),
        .m_axil_rresp  (rresp),
        .m_axil_rvalid (rvalid),
        .m_axil_rready (rready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (awvalid && awready) aw_cnt <= aw_cnt + 1;
        if (wvalid && wready) w_cnt <= w_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk_b({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chk_b({tag, "_busy"}, busy, 1'b0);
        chk_b({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk_w({tag, "_valids"},
              64'({awvalid, wvalid, bready, arvalid, rready}), 64'h0);
    endtask

    task automatic send(input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [SW-1:0] s);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        tick();
        tick();
        idle_chk("reset");
        chk_w("reset_rsp", 64'({rsp_write, rsp_resp, rsp_rdata}), 64'h0);
        chk_w("reset_addr", 64'(awaddr), 64'h0);
        rst = 1'b0;
        tick();

        // Write, slave always ready
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        rsp_ready = 1'b1;
        send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        tick();
        cmd_valid = 1'b0;
        chk_b("w1_c1_awvalid", awvalid, 1'b1);
        chk_b("w1_c1_wvalid", wvalid, 1'b1);
        chk_b("w1_c1_cmd_ready", cmd_ready, 1'b0);
        chk_b("w1_c1_busy", busy, 1'b1);
        chk_w("w1_awaddr", 64'(awaddr), 64'h10);
        chk_w("w1_wdata", 64'(wdata), 64'hDEADBEEF);
        chk_w("w1_wstrb", 64'(wstrb), 64'hF);
        chk_w("w1_awprot", 64'(awprot), 64'h0);
        tick();
        chk_b("w1_c2_awvalid", awvalid, 1'b0);
        chk_b("w1_c2_wvalid", wvalid, 1'b0);
        chk_b("w1_c2_bready", bready, 1'b1);
        chk_b("w1_c2_rsp_valid", rsp_valid, 1'b0);
        tick();
        chk_b("w1_c3_rsp_valid", rsp_valid, 1'b1);
        chk_b("w1_c3_rsp_write", rsp_write, 1'b1);
        chk_w("w1_c3_rsp_resp", 64'(rsp_resp), 64'h0);
        chk_w("w1_c3_rsp_rdata", 64'(rsp_rdata), 64'h0);
        chk_b("w1_c3_bready", bready, 1'b0);
        tick();
        idle_chk("w1_c4");

        // Write, W accepted three cycles before AW
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        aw0 = aw_cnt; w0 = w_cnt;
        send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        tick();
        cmd_valid = 1'b0;
        chk_b("w2_c1_awvalid", awvalid, 1'b1);
        chk_b("w2_c1_wvalid", wvalid, 1'b1);
        chk_b("w2_c1_bready", bready, 1'b0);
        wready = 1'b1;
        tick();
        wready = 1'b0;
        for (int c = 2; c <= 3; c++) begin
            chk_b($sformatf("w2_c%0d_wvalid", c), wvalid, 1'b0);
            chk_b($sformatf("w2_c%0d_awvalid", c), awvalid, 1'b1);
            chk_b($sformatf("w2_c%0d_bready", c), bready, 1'b0);
            chk_w($sformatf("w2_c%0d_awaddr", c), 64'(awaddr), 64'h10);
            tick();
        end
        chk_b("w2_c4_awvalid", awvalid, 1'b1);
        chk_b("w2_c4_bready", bready, 1'b0);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        chk_b("w2_c5_awvalid", awvalid, 1'b0);
        chk_b("w2_c5_bready", bready, 1'b1);
        chk_w("w2_aw_count", 64'(aw_cnt - aw0), 64'd1);
        chk_w("w2_w_count", 64'(w_cnt - w0), 64'd1);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        chk_b("w2_c6_rsp_valid", rsp_valid, 1'b1);
        chk_b("w2_c6_rsp_write", rsp_write, 1'b1);
        tick();
        idle_chk("w2_c7");

        // Read with delayed arready and a 4-cycle rvalid delay
        send(1'b0, 32'h10, 32'h0, 4'h0);
        tick();
        cmd_valid = 1'b0;
        chk_b("r1_c1_arvalid", arvalid, 1'b1);
        chk_w("r1_c1_araddr", 64'(araddr), 64'h10);
        chk_b("r1_c1_awvalid", awvalid, 1'b0);
        tick();
        chk_b("r1_c2_arvalid", arvalid, 1'b1);
        chk_w("r1_c2_araddr", 64'(araddr), 64'h10);
        chk_b("r1_c2_rready", rready, 1'b0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk_b("r1_c3_arvalid", arvalid, 1'b0);
        for (int c = 3; c <= 6; c++) begin
            chk_b($sformatf("r1_c%0d_rready", c), rready, 1'b1);
            chk_b($sformatf("r1_c%0d_rsp_valid", c), rsp_valid, 1'b0);
            tick();
        end
        rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b00;
        tick();
        rvalid = 1'b0; rdata = '0;
        chk_b("r1_c8_rsp_valid", rsp_valid, 1'b1);
        chk_w("r1_c8_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        chk_b("r1_c8_rsp_write", rsp_write, 1'b0);
        chk_w("r1_c8_rsp_resp", 64'(rsp_resp), 64'h0);
        chk_b("r1_c8_rready", rready, 1'b0);
        tick();
        idle_chk("r1_c9");

        // Read returning SLVERR, response held one cycle
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b10;
        rsp_ready = 1'b0;
        send(1'b0, 32'h44, 32'h0, 4'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk_b("r2_c2_rready", rready, 1'b1);
        tick();
        chk_b("r2_c3_rsp_valid", rsp_valid, 1'b1);
        chk_w("r2_c3_rsp_resp", 64'(rsp_resp), 64'h2);
        chk_w("r2_c3_rsp_rdata", 64'(rsp_rdata), 64'h12345678);
        tick();
        chk_b("r2_c4_rsp_valid", rsp_valid, 1'b1);
        chk_b("r2_c4_busy", busy, 1'b1);
        rsp_ready = 1'b1;
        tick();
        idle_chk("r2_c5");
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;

        // Back-to-back: DECERR write held 5 cycles, then a queued read
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b11;
        rsp_ready = 1'b0;
        send(1'b1, 32'h30, 32'hCAFEF00D, 4'h3);
        tick();
        send(1'b0, 32'h20, 32'h0, 4'h0);
        tick();
        tick();
        for (int c = 3; c <= 7; c++) begin
            chk_b($sformatf("bb_c%0d_cmd_ready", c), cmd_ready, 1'b0);
            chk_b($sformatf("bb_c%0d_rsp_valid", c), rsp_valid, 1'b1);
            chk_b($sformatf("bb_c%0d_rsp_write", c), rsp_write, 1'b1);
            chk_w($sformatf("bb_c%0d_rsp_resp", c), 64'(rsp_resp), 64'h3);
            chk_w($sformatf("bb_c%0d_rsp_rdata", c), 64'(rsp_rdata), 64'h0);
            chk_b($sformatf("bb_c%0d_arvalid", c), arvalid, 1'b0);
            tick();
        end
        rsp_ready = 1'b1;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        tick();
        chk_b("bb_c9_cmd_ready", cmd_ready, 1'b1);
        chk_b("bb_c9_rsp_valid", rsp_valid, 1'b0);
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h0BADCAFE; rresp = 2'b00;
        tick();
        cmd_valid = 1'b0;
        chk_b("bb_c10_arvalid", arvalid, 1'b1);
        chk_w("bb_c10_araddr", 64'(araddr), 64'h20);
        chk_b("bb_c10_cmd_ready", cmd_ready, 1'b0);
        tick();
        tick();
        chk_b("bb_c12_rsp_valid", rsp_valid, 1'b1);
        chk_b("bb_c12_rsp_write", rsp_write, 1'b0);
        chk_w("bb_c12_rsp_rdata", 64'(rsp_rdata), 64'h0BADCAFE);
        tick();
        idle_chk("bb_c13");
        arready = 1'b0; rvalid = 1'b0; rdata = '0;

        // Reset while AW/W are pending
        send(1'b1, 32'h50, 32'h11223344, 4'hF);
        tick();
        cmd_valid = 1'b0;
        chk_b("rst_c1_awvalid", awvalid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_chk("rst_c2");
        tick();
        idle_chk("rst_c3");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
